rrl_seq: RTL and testbench



---
 rtl/rrl_seq_if.sv | 37 +++
 rtl/rrl_seq.sv | 113 +++++++++++
 tb/tb_rrl_seq.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rrl_seq_if.sv
// rrl_seq_if: request/response bundle for the sequential rotate-right unit.
//
// Signals
//   start  master->slave  request, taken only when the unit can accept
//   In     master->slave  16-bit operand, captured with an accepted start
//   Cnt    master->slave  4-bit right-rotate amount, captured with an accepted start
//   Out    slave->master  registered result, valid while done=1, held afterwards
//   busy   slave->master  high while a rotate is in progress
//   done   slave->master  one-cycle pulse when Out holds a new result
interface rrl_seq_if;
  logic        start;
  logic [15:0] In;
  logic [3:0]  Cnt;
  logic [15:0] Out;
  logic        busy;
  logic        done;

  // Controller side (ALU sequencer or testbench).
  modport master (
    output start,
    output In,
    output Cnt,
    input  Out,
    input  busy,
    input  done
  );

  // Rotate unit side.
  modport slave (
    input  start,
    input  In,
    input  Cnt,
    output Out,
    output busy,
    output done
  );
endinterface

// File: rtl/rrl_seq.sv
// rrl_seq: sequential 16-bit rotate-right unit.
//
// Rotates a 16-bit operand right by a 4-bit count, one log-stage per clock
// (by 1, 2, 4, then 8). A request accepted at edge E0 produces done=1 with the
// result on Out in the cycle after E4. Requests are accepted in IDLE and in
// the DONE cycle, so a held start yields one result every 5 cycles.
//
// Ports
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    rrl_seq_if.slave: start/In/Cnt in, Out/busy/done out (all registered)
module rrl_seq (
  input  logic         clk,
  input  logic         rst_n,
  rrl_seq_if.slave     bus
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRot  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [1:0]  r_stage;
  logic [1:0]  w_stage_next;
  logic [15:0] r_d;
  logic [15:0] w_d_next;
  logic [15:0] w_d_rot;
  logic [3:0]  r_c;
  logic [3:0]  w_c_next;
  logic [15:0] r_out;
  logic [15:0] w_out_next;
  logic        r_busy;
  logic        w_busy_next;
  logic        r_done;
  logic        w_done_next;

  // One log-stage of the rotator: stage k rotates right by 2^k when C[k] is set.
  always_comb begin
    w_d_rot = r_d;
    case (r_stage)
      2'd0:    if (r_c[0]) w_d_rot = {r_d[0],   r_d[15:1]};
      2'd1:    if (r_c[1]) w_d_rot = {r_d[1:0], r_d[15:2]};
      2'd2:    if (r_c[2]) w_d_rot = {r_d[3:0], r_d[15:4]};
      default: if (r_c[3]) w_d_rot = {r_d[7:0], r_d[15:8]};
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_stage_next = r_stage;
    w_d_next     = r_d;
    w_c_next     = r_c;
    w_out_next   = r_out;

    case (r_state)
      // IDLE and DONE accept identically; DONE falls back to IDLE otherwise.
      StIdle, StDone: begin
        if (bus.start) begin
          w_d_next     = bus.In;
          w_c_next     = bus.Cnt;
          w_stage_next = 2'd0;
          w_state_next = StRot;
        end else begin
          w_state_next = StIdle;
        end
      end
      // start is deliberately ignored here; the in-flight operand is untouched.
      StRot: begin
        w_d_next     = w_d_rot;
        w_stage_next = r_stage + 2'd1;
        if (r_stage == 2'd3) begin
          w_out_next   = w_d_rot;
          w_state_next = StDone;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    // Flags are registered from the next state so they line up with it.
    w_busy_next = (w_state_next == StRot);
    w_done_next = (w_state_next == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_stage <= 2'd0;
      r_d     <= 16'h0000;
      r_c     <= 4'h0;
      r_out   <= 16'h0000;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_stage <= w_stage_next;
      r_d     <= w_d_next;
      r_c     <= w_c_next;
      r_out   <= w_out_next;
      r_busy  <= w_busy_next;
      r_done  <= w_done_next;
    end
  end

  assign bus.Out  = r_out;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_rrl_seq.sv
// tb_rrl_seq: scoreboard bench for rrl_seq. The driver pushes the expected
// result and the cycle it must appear in; a monitor pops on every done pulse.
module tb_rrl_seq;

  logic clk;
  logic rst_n;
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [15:0] out;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  rrl_seq_if u_if ();

  rrl_seq u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0 && sb_q[0].due < cyc) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_missing: no done by cycle %0d, expected at %0d with Out 0x%h",
               cyc, sb_q[0].due, sb_q[0].out);
      void'(sb_q.pop_front());
    end
    if (u_if.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: done with Out 0x%h at cycle %0d, none expected",
                 u_if.Out, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("result", {16'h0, u_if.Out}, {16'h0, e.out});
        chk("latency", cyc, e.due);
      end
    end
  end

  // Single isolated rotate with busy profile and result-hold checks.
  task automatic op(input logic [15:0] a, input logic [3:0] n, input logic [15:0] e);
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.In    = a;
    u_if.Cnt   = n;
    sb_q.push_back('{out: e, due: cyc + 5});
    @(negedge clk);
    u_if.start = 1'b0;
    chk("busy_rot", {31'h0, u_if.busy}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      chk("busy_rot", {31'h0, u_if.busy}, 32'h1);
    end
    @(negedge clk);
    chk("busy_done", {31'h0, u_if.busy}, 32'h0);
    chk("done_pulse", {31'h0, u_if.done}, 32'h1);
    @(negedge clk);
    chk("out_hold", {16'h0, u_if.Out}, {16'h0, e});
    chk("done_one_cycle", {31'h0, u_if.done}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start asserted: nothing may start.
    rst_n      = 1'b0;
    u_if.start = 1'b1;
    u_if.In    = 16'h1234;
    u_if.Cnt   = 4'd1;
    repeat (2) @(negedge clk);
    chk("rst_out", {16'h0, u_if.Out}, 32'h0);
    chk("rst_busy", {31'h0, u_if.busy}, 32'h0);
    chk("rst_done", {31'h0, u_if.done}, 32'h0);
    u_if.start = 1'b0;
    rst_n      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", {31'h0, u_if.busy}, 32'h0);
    end

    // Basic and boundary rotates.
    op(16'h1234, 4'd4,  16'h4123);
    op(16'h1234, 4'd8,  16'h3412);
    op(16'hBEEF, 4'd0,  16'hBEEF);
    op(16'h0001, 4'd1,  16'h8000);
    op(16'h8001, 4'd15, 16'h0003);

    // start pulsed during ROT must be ignored.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.In    = 16'h00F0;
    u_if.Cnt   = 4'd4;
    sb_q.push_back('{out: 16'h000F, due: cyc + 5});
    @(negedge clk);
    u_if.start = 1'b0;
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.In    = 16'hFFFF;
    u_if.Cnt   = 4'd1;
    @(negedge clk);
    u_if.start = 1'b0;
    repeat (12) @(negedge clk);
    chk("busy_ignored_drained", sb_q.size(), 32'h0);

    // Back-to-back: second request presented in the DONE cycle.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.In    = 16'h0001;
    u_if.Cnt   = 4'd2;
    sb_q.push_back('{out: 16'h4000, due: cyc + 5});
    repeat (4) begin
      @(negedge clk);
      chk("b2b_busy1", {31'h0, u_if.busy}, 32'h1);
    end
    @(negedge clk);
    chk("b2b_gap1", {31'h0, u_if.busy}, 32'h0);
    u_if.In  = 16'h0001;
    u_if.Cnt = 4'd3;
    sb_q.push_back('{out: 16'h2000, due: cyc + 5});
    @(negedge clk);
    u_if.start = 1'b0;
    chk("b2b_busy2", {31'h0, u_if.busy}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      chk("b2b_busy2", {31'h0, u_if.busy}, 32'h1);
    end
    @(negedge clk);
    chk("b2b_gap2", {31'h0, u_if.busy}, 32'h0);
    repeat (3) @(negedge clk);

    // Reset during stage 2 aborts with no done pulse.
    @(negedge clk);
    u_if.start = 1'b1;
    u_if.In    = 16'hA5A5;
    u_if.Cnt   = 4'd3;
    @(negedge clk);
    u_if.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_out", {16'h0, u_if.Out}, 32'h0);
    chk("abort_busy", {31'h0, u_if.busy}, 32'h0);
    chk("abort_done", {31'h0, u_if.done}, 32'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_idle_busy", {31'h0, u_if.busy}, 32'h0);
    op(16'hA5A5, 4'd3, 16'hB4B4);

    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk("scoreboard_drained", sb_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
